// File: rtl/ndro_drv_pkg.sv
// Shared types and encodings for the NDRO pulse driver.
package ndro_drv_pkg;

    // Command opcode encodings on cmd_op
    localparam logic [1:0] ENC_NOP   = 2'b00;
    localparam logic [1:0] ENC_SET   = 2'b01;
    localparam logic [1:0] ENC_RESET = 2'b10;
    localparam logic [1:0] ENC_READ  = 2'b11;

    typedef enum logic [1:0] {
        OP_NOP   = ENC_NOP,
        OP_SET   = ENC_SET,
        OP_RESET = ENC_RESET,
        OP_READ  = ENC_READ
    } ndo_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_GAP
    } ndo_state_t;

endpackage

// File: rtl/toggle_pulse_det.sv
// Turns a toggle-encoded SFQ line into a one-cycle pulse by comparing it with
// its registered value. The history follows the line even in reset so that
// no phantom pulse appears when reset is released.
module toggle_pulse_det (
    input  logic clk,
    input  logic reset,
    input  logic tog_in,
    output logic pulse
);

    logic hist;

    // History register tracks the line level every cycle, including reset
    always_ff @(posedge clk) begin
        hist <= tog_in;
    end

    assign pulse = ~reset & (tog_in ^ hist);

endmodule

// File: rtl/ndro_pulse_driver.sv
// Command-driven driver around one NDRO cell: issues toggle-encoded
// set/reset/clk pulses with enforced spacing, times the read window on the
// cell's out line, and tracks a shadow bit, spurious-output flag and resout count.
module ndro_pulse_driver
    import ndro_drv_pkg::*;
#(
    parameter int SEP_CYC = 2,
    parameter int RD_WIN  = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             ndo_set,
    output logic             ndo_reset,
    output logic             ndo_clk,
    input  logic             ndo_out,
    input  logic             ndo_resout,
    output logic             rsp_valid,
    output logic             rsp_data,
    output logic             rsp_err,
    output logic             shadow,
    output logic             spur_err,
    output logic [CNT_W-1:0] resout_cnt
);

    localparam int MAX_CYC = (SEP_CYC > RD_WIN) ? SEP_CYC : RD_WIN;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(SEP_CYC - 1);
    localparam logic [CW-1:0] WIN_LOAD = CW'(RD_WIN - 1);

    ndo_state_t      state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            tog_set, tog_rst, tog_clk;
    logic            shadow_n;
    logic            rsp_fire, rsp_bit;
    logic            out_pulse, resout_pulse;
    ndo_op_t         op;

    assign op        = ndo_op_t'(cmd_op);
    assign cmd_ready = (state == S_IDLE);

    toggle_pulse_det u_out_det (
        .clk    (clk),
        .reset  (reset),
        .tog_in (ndo_out),
        .pulse  (out_pulse)
    );

    toggle_pulse_det u_resout_det (
        .clk    (clk),
        .reset  (reset),
        .tog_in (ndo_resout),
        .pulse  (resout_pulse)
    );

    // Next-state logic: command decode, read-window timing and pulse spacing
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        tog_set  = 1'b0;
        tog_rst  = 1'b0;
        tog_clk  = 1'b0;
        shadow_n = shadow;
        rsp_fire = 1'b0;
        rsp_bit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_SET: begin
                            tog_set  = 1'b1;
                            shadow_n = 1'b1;
                            state_n  = S_GAP;
                            cnt_n    = GAP_LOAD;
                        end
                        OP_RESET: begin
                            tog_rst  = 1'b1;
                            shadow_n = 1'b0;
                            state_n  = S_GAP;
                            cnt_n    = GAP_LOAD;
                        end
                        OP_READ: begin
                            tog_clk  = 1'b1;
                            state_n  = S_RD_WAIT;
                            cnt_n    = WIN_LOAD;
                        end
                        default: ;
                    endcase
                end
            end
            S_RD_WAIT: begin
                if (out_pulse) begin
                    rsp_fire = 1'b1;
                    rsp_bit  = 1'b1;
                    state_n  = S_GAP;
                    cnt_n    = GAP_LOAD;
                end else if (cnt == '0) begin
                    rsp_fire = 1'b1;
                    state_n  = S_GAP;
                    cnt_n    = GAP_LOAD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, pulse lines, response and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ndo_set    <= 1'b0;
            ndo_reset  <= 1'b0;
            ndo_clk    <= 1'b0;
            shadow     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 1'b0;
            rsp_err    <= 1'b0;
            spur_err   <= 1'b0;
            resout_cnt <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ndo_set   <= ndo_set ^ tog_set;
            ndo_reset <= ndo_reset ^ tog_rst;
            ndo_clk   <= ndo_clk ^ tog_clk;
            shadow    <= shadow_n;
            rsp_valid <= rsp_fire;
            rsp_data  <= rsp_fire & rsp_bit;
            rsp_err   <= rsp_fire & (rsp_bit ^ shadow);
            if (out_pulse && (state != S_RD_WAIT)) begin
                spur_err <= 1'b1;
            end
            if (resout_pulse && (resout_cnt != '1)) begin
                resout_cnt <= resout_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ndro_pulse_driver.sv
// Scoreboard-based bench for ndro_pulse_driver: expected read responses are
// queued when a READ is accepted and compared when rsp_valid appears.
module tb_ndro_pulse_driver;
    import ndro_drv_pkg::*;

    localparam int SEP_CYC = 2;
    localparam int RD_WIN  = 4;
    localparam int CNT_W   = 8;

    typedef struct {
        int   cyc;
        logic data;
        logic err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic             cmd_ready;
    logic             ndo_set, ndo_reset, ndo_clk;
    logic             ndo_out = 1'b0;
    logic             ndo_resout = 1'b0;
    logic             rsp_valid, rsp_data, rsp_err;
    logic             shadow, spur_err;
    logic [CNT_W-1:0] resout_cnt;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic set_m = 1'b0, rst_m = 1'b0, clk_m = 1'b0, shadow_m = 1'b0;

    ndro_pulse_driver #(.SEP_CYC(SEP_CYC), .RD_WIN(RD_WIN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .ndo_set    (ndo_set),
        .ndo_reset  (ndo_reset),
        .ndo_clk    (ndo_clk),
        .ndo_out    (ndo_out),
        .ndo_resout (ndo_resout),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .shadow     (shadow),
        .spur_err   (spur_err),
        .resout_cnt (resout_cnt)
    );

    // Free-running clock and edge counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every rsp_valid must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                if (cyc !== e.cyc) begin
                    n_fail++;
                    $display("[TB] FAIL rsp_cycle: got %0d, required %0d", cyc, e.cyc);
                end
                n_checks++;
                if (rsp_data !== e.data) begin
                    n_fail++;
                    $display("[TB] FAIL rsp_data: got %b, required %b", rsp_data, e.data);
                end
                n_checks++;
                if (rsp_err !== e.err) begin
                    n_fail++;
                    $display("[TB] FAIL rsp_err: got %b, required %b", rsp_err, e.err);
                end
            end
        end
    end

    // Reset for n cycles; returns at the negedge reset is released
    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        set_m = 1'b0; rst_m = 1'b0; clk_m = 1'b0; shadow_m = 1'b0;
        sb.delete();
    endtask

    // Present one command from a negedge; returns at the negedge after acceptance
    task automatic send_cmd(input logic [1:0] op, output int acc);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL ready_timeout: cmd_ready=%b, required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        case (op)
            ENC_SET:   begin set_m = ~set_m; shadow_m = 1'b1; end
            ENC_RESET: begin rst_m = ~rst_m; shadow_m = 1'b0; end
            ENC_READ:  clk_m = ~clk_m;
            default: ;
        endcase
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = ENC_NOP;
    endtask

    // Wait, bounded, for all queued responses to appear
    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL rsp_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        apply_reset(3);
        n_checks++;
        if ({cmd_ready, ndo_set, ndo_reset, ndo_clk, rsp_valid, rsp_data, rsp_err, shadow, spur_err} !== 9'b1_0000_0000
            || resout_cnt !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: ready=%b set=%b rst=%b clk=%b rv=%b rd=%b re=%b sh=%b sp=%b cnt=%0d, required ready=1 rest 0",
                     cmd_ready, ndo_set, ndo_reset, ndo_clk, rsp_valid, rsp_data, rsp_err, shadow, spur_err, resout_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL idle_quiet: rsp_valid=%b cmd_ready=%b, required 0/1", rsp_valid, cmd_ready);
            end
        end
    endtask

    task automatic test_set_spacing();
        int n, n2;
        logic [2:0] ready_seen;
        send_cmd(ENC_SET, n);
        n_checks++;
        if ({ndo_set, ndo_reset, ndo_clk} !== {set_m, rst_m, clk_m} || ndo_set !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL set_pulse: lines=%b, required %b", {ndo_set, ndo_reset, ndo_clk}, {set_m, rst_m, clk_m});
        end
        n_checks++;
        if (shadow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL set_shadow: got %b, required 1", shadow);
        end
        ready_seen[0] = cmd_ready;
        @(negedge clk);
        ready_seen[1] = cmd_ready;
        @(negedge clk);
        ready_seen[2] = cmd_ready;
        n_checks++;
        if (ready_seen !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL gap_ready: got %b, required 100", ready_seen);
        end
        send_cmd(ENC_NOP, n2);
        n_checks++;
        if (n2 !== n + SEP_CYC + 1) begin
            n_fail++;
            $display("[TB] FAIL next_accept: got edge %0d, required %0d", n2, n + SEP_CYC + 1);
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL nop_ready: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_read_hit();
        int n;
        send_cmd(ENC_SET, n);
        send_cmd(ENC_READ, n);
        sb.push_back('{cyc: n + 3, data: 1'b1, err: 1'b1 ^ shadow_m});
        n_checks++;
        if ({ndo_set, ndo_reset, ndo_clk} !== {set_m, rst_m, clk_m}) begin
            n_fail++;
            $display("[TB] FAIL read_pulse: lines=%b, required %b", {ndo_set, ndo_reset, ndo_clk}, {set_m, rst_m, clk_m});
        end
        repeat (2) @(negedge clk);
        ndo_out = ~ndo_out;
        drain();
        repeat (4) @(negedge clk);
        n_checks++;
        if (spur_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL hit_no_spur: got %b, required 0", spur_err);
        end
    endtask

    task automatic test_read_timeout();
        int n;
        send_cmd(ENC_RESET, n);
        n_checks++;
        if (shadow !== 1'b0 || ndo_reset !== rst_m) begin
            n_fail++;
            $display("[TB] FAIL reset_cmd: shadow=%b ndo_reset=%b, required 0/%b", shadow, ndo_reset, rst_m);
        end
        send_cmd(ENC_READ, n);
        sb.push_back('{cyc: n + RD_WIN, data: 1'b0, err: shadow_m});
        drain();
        send_cmd(ENC_SET, n);
        send_cmd(ENC_READ, n);
        sb.push_back('{cyc: n + RD_WIN, data: 1'b0, err: shadow_m});
        drain();
    endtask

    task automatic test_window_edge();
        int n;
        send_cmd(ENC_READ, n);
        sb.push_back('{cyc: n + RD_WIN, data: 1'b1, err: 1'b1 ^ shadow_m});
        repeat (RD_WIN - 1) @(negedge clk);
        ndo_out = ~ndo_out;
        @(negedge clk);
        n_checks++;
        if (spur_err !== 1'b0 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL last_edge: spur=%b rsp_valid=%b, required 0/1", spur_err, rsp_valid);
        end
        ndo_out = ~ndo_out;
        @(negedge clk);
        n_checks++;
        if (spur_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rsp_cycle_spur: got %b, required 1", spur_err);
        end
        drain();
        apply_reset(1);
    endtask

    task automatic test_spur_and_count();
        n_checks++;
        if (spur_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL spur_pre: got %b, required 0", spur_err);
        end
        ndo_out = ~ndo_out;
        @(negedge clk);
        n_checks++;
        if (spur_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL spur_idle: got %b, required 1", spur_err);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (spur_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL spur_sticky: got %b, required 1", spur_err);
        end
        apply_reset(1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (spur_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL spur_cleared: got %b, required 0", spur_err);
        end
        for (int i = 1; i <= 300; i++) begin
            ndo_resout = ~ndo_resout;
            @(negedge clk);
            if (i == 254) begin
                n_checks++;
                if (resout_cnt !== 8'd254) begin
                    n_fail++;
                    $display("[TB] FAIL resout_254: got %0d, required 254", resout_cnt);
                end
            end
        end
        n_checks++;
        if (resout_cnt !== 8'd255) begin
            n_fail++;
            $display("[TB] FAIL resout_sat: got %0d, required 255", resout_cnt);
        end
        apply_reset(1);
        n_checks++;
        if (resout_cnt !== '0) begin
            n_fail++;
            $display("[TB] FAIL resout_reset: got %0d, required 0", resout_cnt);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        send_cmd(ENC_READ, n);
        reset   = 1'b1;
        ndo_out = ~ndo_out;
        @(negedge clk);
        ndo_resout = ~ndo_resout;
        apply_reset(1);
        n_checks++;
        if ({cmd_ready, ndo_set, ndo_reset, ndo_clk} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL abort_state: ready/set/rst/clk=%b, required 1000", {cmd_ready, ndo_set, ndo_reset, ndo_clk});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || {ndo_set, ndo_reset, ndo_clk} !== 3'b000) begin
                n_fail++;
                $display("[TB] FAIL abort_quiet: rsp_valid=%b lines=%b, required 0/000", rsp_valid, {ndo_set, ndo_reset, ndo_clk});
            end
        end
        n_checks++;
        if (spur_err !== 1'b0 || resout_cnt !== '0) begin
            n_fail++;
            $display("[TB] FAIL abort_ignore: spur=%b cnt=%0d, required 0/0", spur_err, resout_cnt);
        end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_set_spacing();
        test_read_hit();
        test_read_timeout();
        test_window_edge();
        test_spur_and_count();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
